// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants: physical tag width and register file sizes.
package ooo_pkg;

  localparam int PHYS_TAG_W    = 6;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int FL_CNT_W      = PHYS_TAG_W + 1;

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
  typedef logic [FL_CNT_W-1:0]   fl_cnt_t;

  // Tags not bound to an architectural register at reset start the free list.
  localparam int        FL_RESET_COUNT = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam fl_cnt_t   FL_MAX_COUNT   = fl_cnt_t'(NUM_PHYS_REGS - 1);

endpackage : ooo_pkg

// File: rtl/phys_tag_free_list.sv
// Physical tag free list: 64-entry circular FIFO, one allocate and two frees per cycle.
// Optional same-cycle free-to-alloc bypass when empty is enabled by FREE_LIST_BYPASS_EN.
module phys_tag_free_list
  import ooo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_req,
  output logic                  alloc_grant,
  output logic [PHYS_TAG_W-1:0] alloc_tag,
  input  logic                  free_0_valid,
  input  logic [PHYS_TAG_W-1:0] free_0_tag,
  input  logic                  free_1_valid,
  input  logic [PHYS_TAG_W-1:0] free_1_tag,
  output logic [FL_CNT_W-1:0]   free_count,
  output logic                  empty,
  output logic                  error
);

  phys_tag_t mem_q [NUM_PHYS_REGS];
  phys_tag_t head_q, head_d;
  phys_tag_t tail_q, tail_d;
  fl_cnt_t   count_q, count_d;
  logic      error_q, error_d;

  logic      f0_nz, f1_nz;
  logic      bypass, byp_slot1;
  logic      f0_cand, f1_cand;
  logic      f0_st, f1_st;
  logic      pop;
  phys_tag_t wr1_idx;

  always_comb begin
    f0_nz     = free_0_valid && (free_0_tag != '0);
    f1_nz     = free_1_valid && (free_1_tag != '0);
    bypass    = 1'b0;
    byp_slot1 = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    if ((count_q == '0) && alloc_req && (f0_nz || f1_nz)) begin
      bypass    = 1'b1;
      byp_slot1 = !f0_nz;
    end
`endif
    // A bypassed tag goes straight to rename and never occupies a FIFO slot.
    f0_cand = f0_nz && !(bypass && !byp_slot1);
    f1_cand = f1_nz && !(bypass && byp_slot1);

    // Slot 0 claims capacity first; slot 1 sees the count including slot 0.
    f0_st   = f0_cand && (count_q < FL_MAX_COUNT);
    f1_st   = f1_cand && ((count_q + fl_cnt_t'(f0_st)) < FL_MAX_COUNT);
    wr1_idx = tail_q + phys_tag_t'(f0_st);

    pop         = alloc_req && (count_q != '0);
    alloc_grant = pop || bypass;
    alloc_tag   = bypass ? (byp_slot1 ? free_1_tag : free_0_tag) : mem_q[head_q];

    head_d  = head_q + phys_tag_t'(pop);
    tail_d  = tail_q + phys_tag_t'(f0_st) + phys_tag_t'(f1_st);
    count_d = count_q + fl_cnt_t'(f0_st) + fl_cnt_t'(f1_st) - fl_cnt_t'(pop);

    error_d = error_q
            || (free_0_valid && (free_0_tag == '0))
            || (free_1_valid && (free_1_tag == '0))
            || (f0_cand && !f0_st)
            || (f1_cand && !f1_st);

    free_count = count_q;
    empty      = (count_q == '0);
    error      = error_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= phys_tag_t'(FL_RESET_COUNT);
      count_q <= fl_cnt_t'(FL_RESET_COUNT);
      error_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // NOTE: the storage array is reset because its contents after reset are
  // architecturally visible (tags 32..63 must be allocatable immediately);
  // a plain data RAM would normally be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        mem_q[i] <= (i < FL_RESET_COUNT) ? phys_tag_t'(NUM_ARCH_REGS + i) : '0;
      end
    end else begin
      if (f0_st) mem_q[tail_q]  <= free_0_tag;
      if (f1_st) mem_q[wr1_idx] <= free_1_tag;
    end
  end

endmodule : phys_tag_free_list

// File: tb/tb_phys_tag_free_list.sv
// Directed self-checking bench for phys_tag_free_list (default or bypass build).
module tb_phys_tag_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic       alloc_grant;
  logic [5:0] alloc_tag;
  logic       free_0_valid;
  logic [5:0] free_0_tag;
  logic       free_1_valid;
  logic [5:0] free_1_tag;
  logic [6:0] free_count;
  logic       empty;
  logic       error;

  int n_cmp  = 0;
  int n_fail = 0;

  phys_tag_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_tag    (alloc_tag),
    .free_0_valid (free_0_valid),
    .free_0_tag   (free_0_tag),
    .free_1_valid (free_1_valid),
    .free_1_tag   (free_1_tag),
    .free_count   (free_count),
    .empty        (empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req    = 1'b0;
    free_0_valid = 1'b0;
    free_0_tag   = '0;
    free_1_valid = 1'b0;
    free_1_tag   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    #1;
  endtask

  // One granted allocation of an expected tag, sampled before the edge.
  task automatic alloc_expect(input string tag, input logic [5:0] exp_tag);
    alloc_req = 1'b1;
    #1;
    check({tag, "_grant"}, alloc_grant, 1);
    check({tag, "_tag"}, alloc_tag, exp_tag);
    tick();
    alloc_req = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    check("rst_grant", alloc_grant, 0);
    check("rst_tag", alloc_tag, 32);
    check("rst_count", free_count, 32);
    check("rst_empty", empty, 0);
    check("rst_error", error, 0);

    // Three allocations: tags 32..34, count 31..29
    for (int i = 0; i < 3; i++) begin
      alloc_expect("alloc3", 6'(32 + i));
      check("alloc3_count", free_count, 31 - i);
    end

    // Drain the rest: last tag 63, then empty and no grant
    for (int i = 3; i < 32; i++) alloc_expect("drain", 6'(32 + i));
    check("drain_count", free_count, 0);
    check("drain_empty", empty, 1);
    alloc_req = 1'b1;
    #1;
    check("empty_no_grant", alloc_grant, 0);
    tick();
    check("empty_hold_count", free_count, 0);
    alloc_req = 1'b0;

    // Two frees into an empty list, then consumed in slot order
    free_0_valid = 1'b1; free_0_tag = 6'd5;
    free_1_valid = 1'b1; free_1_tag = 6'd7;
    tick();
    idle_inputs();
    check("dual_free_count", free_count, 2);
    check("dual_free_empty", empty, 0);
    alloc_expect("dual_first", 6'd5);
    alloc_expect("dual_second", 6'd7);
    check("dual_after_count", free_count, 0);

    // Empty list, alloc with a same-cycle free
    alloc_req = 1'b1;
    free_0_valid = 1'b1; free_0_tag = 6'd9;
    #1;
`ifdef FREE_LIST_BYPASS_EN
    check("byp_grant", alloc_grant, 1);
    check("byp_tag", alloc_tag, 9);
    tick();
    idle_inputs();
    check("byp_count", free_count, 0);
    check("byp_empty", empty, 1);
`else
    check("nobyp_grant", alloc_grant, 0);
    tick();
    idle_inputs();
    check("nobyp_count", free_count, 1);
    alloc_expect("nobyp_next", 6'd9);
    check("nobyp_after_count", free_count, 0);
`endif
    check("no_error_yet", error, 0);

    // Alloc plus two frees at count 32: frees land after tag 63
    do_reset();
    alloc_req = 1'b1;
    free_0_valid = 1'b1; free_0_tag = 6'd10;
    free_1_valid = 1'b1; free_1_tag = 6'd11;
    #1;
    check("mix_grant", alloc_grant, 1);
    check("mix_tag", alloc_tag, 32);
    tick();
    idle_inputs();
    check("mix_count", free_count, 33);
    for (int i = 33; i < 64; i++) alloc_expect("mix_drain", 6'(i));
    alloc_expect("mix_wrap0", 6'd10);
    alloc_expect("mix_wrap1", 6'd11);
    check("mix_empty", empty, 1);

    // Fill to capacity: 31 more tags fit, the 32nd is dropped
    do_reset();
    for (int i = 0; i < 15; i++) begin
      free_0_valid = 1'b1; free_0_tag = 6'(2 * i + 1);
      free_1_valid = 1'b1; free_1_tag = 6'(2 * i + 2);
      tick();
    end
    idle_inputs();
    check("fill_count62", free_count, 62);
    check("fill_error0", error, 0);
    free_0_valid = 1'b1; free_0_tag = 6'd40;
    free_1_valid = 1'b1; free_1_tag = 6'd41;
    tick();
    idle_inputs();
    check("ovf_count", free_count, 63);
    check("ovf_error", error, 1);
    for (int i = 0; i < 32; i++) alloc_expect("ovf_drain_a", 6'(32 + i));
    for (int i = 1; i <= 30; i++) alloc_expect("ovf_drain_b", 6'(i));
    alloc_expect("ovf_last", 6'd40);
    check("ovf_drained_empty", empty, 1);
    check("ovf_error_sticky", error, 1);

    // Free of tag 0 is ignored and sets a sticky error
    do_reset();
    check("rst2_error", error, 0);
    free_0_valid = 1'b1; free_0_tag = 6'd0;
    tick();
    idle_inputs();
    check("x0_count", free_count, 32);
    check("x0_error", error, 1);
    tick();
    tick();
    check("x0_error_hold", error, 1);
    check("x0_tag_head", alloc_tag, 32);
    do_reset();
    check("rst3_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_phys_tag_free_list

// File: doc/phys_tag_free_list.md
PHYS_TAG_FREE_LIST -- requirements
Module: phys_tag_free_list

Interface
REQ-001 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: alloc_req  input  1  rename requests one physical tag this cycle.
REQ-004 SHALL have port: alloc_grant  output  1  tag on alloc_tag is consumed this cycle.
REQ-005 SHALL have port: alloc_tag  output  6  physical tag offered to rename.
REQ-006 SHALL have port: free_0_valid  input  1  ROB retire slot 0 frees a tag.
REQ-007 SHALL have port: free_0_tag  input  6  tag freed by slot 0.
REQ-008 SHALL have port: free_1_valid  input  1  ROB retire slot 1 frees a tag.
REQ-009 SHALL have port: free_1_tag  input  6  tag freed by slot 1.
REQ-010 SHALL have port: free_count  output  7  number of tags currently held.
REQ-011 SHALL have port: empty  output  1  free_count == 0.
REQ-012 SHALL have port: error  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL store free tags in a 64-entry circular FIFO with 6-bit head/tail pointers wrapping 63->0 and a 7-bit count.
REQ-014 SHALL drive alloc_tag combinationally from the entry at head; value is don't-care when empty.
REQ-015 SHALL assert alloc_grant = alloc_req && !empty (same cycle, zero latency); on grant head increments at next edge.
REQ-016 SHALL write valid frees at tail in slot order (slot 0 first, then slot 1); tail advances by number of accepted frees (0, 1 or 2).
REQ-017 SHALL update count = count + accepted_frees - alloc_grant each cycle; allocation and up to two frees in the same cycle all take effect.
REQ-018 SHALL ignore any free of tag 0 (x0 mapping is permanent) and set error.
REQ-019 SHALL drop a free that would raise count above 63 and set error; slot 0 accepted before slot 1 is evaluated.
REQ-020 SHALL hold error at 1 once set until reset.
REQ-021 SHALL not check duplicate frees of a non-zero tag; correctness is the ROB's responsibility.

Reset
REQ-022 SHALL on reset load entries 0..31 with tags 32..63 in ascending order, head=0, tail=32, count=32, error=0.
REQ-023 SHALL reset asynchronously at any point; in-flight grant or free in the reset cycle is discarded.
REQ-024 SHALL present after reset: alloc_grant=0 (if alloc_req=0), alloc_tag=32, free_count=32, empty=0, error=0.

Configuration
REQ-025 SHALL support macro FREE_LIST_BYPASS_EN.
REQ-026 With FREE_LIST_BYPASS_EN defined: when empty, alloc_req=1 and a valid non-zero free arrives, SHALL grant that cycle with alloc_tag = free_0_tag (else free_1_tag), that tag not written to FIFO, other free stored normally.
REQ-027 Without FREE_LIST_BYPASS_EN: alloc_grant=0 whenever empty; same-cycle frees are stored and available next cycle.

Structure
REQ-028 SHALL take PHYS_TAG_W=6, NUM_PHYS_REGS=64, NUM_ARCH_REGS=32 from shared package ooo_pkg; reset contents derived from these constants.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 Reset then alloc_req=1 for 3 cycles -> grants with tags 32, 33, 34; free_count 31, 30, 29.
REQ-031 From reset, alloc 32 times -> last tag 63, empty=1; next alloc_req -> alloc_grant=0 (bypass off).
REQ-032 Empty, free_0=5 and free_1=7 same cycle -> count=2; next two grants give 5 then 7.
REQ-033 Count=32, alloc_req=1 with free_0=10, free_1=11 same cycle -> count=33, tags 10,11 appended after 63 wrap-around order.
REQ-034 free_0_tag=0 valid -> not stored, count unchanged, error=1 and stays 1 until reset.
REQ-035 With FREE_LIST_BYPASS_EN, empty, alloc_req=1, free_0=9 -> alloc_grant=1, alloc_tag=9, count stays 0.
